// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Latency: 3-5 cycles per instruction with mem_ready high; outputs decode from the state register.
// Backpressure: mem_ready low stretches FETCH, MEMREAD and MEMWRITE one cycle at a time.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   op, funct3, funct7b5          instruction fields from IR
//   zero                          ALU zero flag, qualifies PCWrite in BEQ
//   mem_ready                     memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   RegWrite, ImmSrc, ALUControl  datapath controls
//   illegal_instr, state          trap flag and current state code (debug)
module multicycle_ctrl #(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal_instr,
   output logic [3:0] state
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   state_t     cur_state;
   logic [1:0] alu_op;
   logic       branch;
   logic       pc_update;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_FETCH;
      end else begin
         case (cur_state)
            S_FETCH:    if (mem_ready) cur_state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: cur_state <= S_MEMADR;
                  OP_R:         cur_state <= S_EXECR;
                  OP_I:         cur_state <= S_EXECI;
                  OP_BEQ:       cur_state <= S_BEQ;
                  OP_JAL:       cur_state <= S_JAL;
                  default: begin
                     if (TRAP_ON_ILLEGAL) cur_state <= S_TRAP;
                     else                 cur_state <= S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               if (op == OP_SW) cur_state <= S_MEMWRITE;
               else             cur_state <= S_MEMREAD;
            end
            S_MEMREAD:  if (mem_ready) cur_state <= S_MEMWB;
            S_MEMWRITE: if (mem_ready) cur_state <= S_FETCH;
            S_EXECR,
            S_EXECI:    cur_state <= S_ALUWB;
            S_TRAP:     cur_state <= S_TRAP;
            // MEMWB, ALUWB, BEQ, JAL and the unused codes 12-15
            default:    cur_state <= S_FETCH;
         endcase
      end
   end

   // Moore decode of the state register; only FETCH (mem_ready) and BEQ (zero)
   // look at live inputs.
   always_comb begin
      alu_op        = 2'b00;
      branch        = 1'b0;
      pc_update     = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      illegal_instr = 1'b0;
      case (cur_state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_write  = mem_ready;
            pc_update = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         S_ALUWB:    reg_write = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         S_TRAP:     illegal_instr = 1'b1;
         default: ;
      endcase
   end

   // Write enables are gated by rst_n so nothing commits while reset is held,
   // even though FETCH would otherwise follow mem_ready.
   assign PCWrite  = rst_n & (pc_update | (branch & zero));
   assign IRWrite  = rst_n & ir_write;
   assign MemWrite = rst_n & mem_write;
   assign RegWrite = rst_n & reg_write;
   assign state    = cur_state;

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // op[5] separates R-type from I-type so addi with bit 30 set stays an add.
   always_comb begin
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

endmodule
